div_ctrl: RTL
=============

# div_ctrl

Sequencer between the execute stage and the 64-bit radix-2 iterative divider. Accepts one M-extension divide/remainder request at a time and resolves divide-by-zero, signed overflow and repeat-operand hits in one cycle without starting the divider. All other requests launch the divider and hold its operands stable until `div_done`. Results are returned on a valid/ready response port, and in-flight work is dropped on pipeline flush.

## Interface
- No parameters. Widths are fixed: XLEN 64, op code 10 bits (`{opcode[6:0], funct3}`), tag 5 bits.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-low reset (reset while `rst == 0` at a rising edge).
- `flush` in 1: kill the current request; has priority over all other inputs.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_op` in 10: one of DIV/DIVU/REM/REMU (`0110011_1xx`) or DIVW/DIVUW/REMW/REMUW (`0111011_1xx`).
- `req_rs1` in 64: dividend.
- `req_rs2` in 64: divisor.
- `req_tag` in 5: destination register, returned unchanged.
- `resp_valid` out 1, `resp_ready` in 1: result handshake.
- `resp_data` out 64: result; W forms are sign-extended from bit 31.
- `resp_tag` out 5: tag of the result.
- `busy` out 1: high in every state except IDLE; drives the hazard unit.
- `div_start` out 1: one-cycle launch pulse to the divider's start input.
- `div_op` out 10, `div_dividend` out 64, `div_divisor` out 64: divider operands, held stable from ISSUE until `div_done`.
- `div_busy` in 1: divider busy.
- `div_done` in 1: one-cycle finish pulse from the divider.
- `div_result` in 64: divider result; valid only while `div_done` is high.

## Operation
- States: IDLE, ISSUE, WAIT, DRAIN, RESP.
- `req_ready = (state == IDLE) && !flush`.
- **Accept:** on `req_valid && req_ready`, latch op, rs1, rs2 and tag. Classify in the same cycle:
  - Divide-by-zero (divisor is 0; low 32 bits for W forms): quotient = all ones; remainder = rs1, or `sext(rs1[31:0])` for W forms.
  - Signed overflow (DIV/REM with rs1 = 0x8000…0 and rs2 = −1; for W forms the 32-bit equivalents): quotient = rs1, or `sext(0x80000000)` for W forms; remainder = 0.
  - Cache hit: cache valid and op, rs1, rs2 all equal the cached values → result = cached result.
  - Unlisted op code: result = 0.
  - Any of the four cases above goes to RESP. Everything else goes to ISSUE.
- **ISSUE:** assert `div_start` for exactly one cycle, only when `div_busy == 0 && div_done == 0`. Otherwise stay in ISSUE. Next state WAIT.
- **WAIT:** when `div_done` is high, capture `div_result` into the result register and the cache (valid, op, rs1, rs2, result), then go to RESP.
- **RESP:** `resp_valid = 1`; data and tag are held. Go to IDLE on `resp_ready`.
- **Flush:**
  - In ISSUE before the pulse: go to IDLE with no launch.
  - In ISSUE after the pulse, or in WAIT: go to DRAIN. Wait for `div_done`, update the cache, emit no response, then go to IDLE.
  - In RESP: drop `resp_valid` and go to IDLE.
  - In IDLE: no request is accepted that cycle.
- The cache is invalidated only by reset. A single entry is sufficient.
- Divider operands, `div_op` and `div_start` are driven from registers, never directly from request inputs.

## Timing
- Reset values: `req_ready` 0 during reset and 1 in the first cycle after; `resp_valid` 0; `resp_data` 0; `resp_tag` 0; `busy` 0; `div_start` 0; `div_op`, `div_dividend`, `div_divisor` 0; cache invalid; state IDLE.
- Fast path: accepted in cycle T, `resp_valid` in T+1.
- Slow path: accepted in T, `div_start` in T+1, `div_done` nominally in T+68, `resp_valid` in T+69.
  - The FSM keys on `div_done` and never counts cycles.
- Back-to-back: response accepted in cycle R, next request earliest in R+1. The divider returns to idle one cycle after `div_done`; the ISSUE guard absorbs any extra latency.
- `rst` asserted mid-operation returns all state to reset values the next cycle. The divider is reset by the same `rst`.

## Structure
- `muldiv_pkg`: op-code constants (DIV … REMUW), state enum, `XLEN = 64`, `TAG_W = 5`. Shared with the decoder and the divider.
- Sub-module `div_special_case` (combinational): inputs op, rs1, rs2; outputs `is_zero`, `is_ovf` and the fast-path result.

## Test plan
- DIVU 100 / 7 → `resp_data` = 14 at T+69; REMU with the same operands → 2. The REMU is not a cache hit because its op differs.
- DIV 0x8000_0000_0000_0000 / −1 → `resp_data` = 0x8000_0000_0000_0000 at T+1; `div_start` never pulses.
- REMW rs1 = 0x1234_5678_8000_0005, rs2 = 0 → `resp_data` = 0xFFFF_FFFF_8000_0005 at T+1.
- DIVW −7 / 2 (slow path) → `resp_data` = 0xFFFF_FFFF_FFFF_FFFD. Repeat the identical request → same value at T+1 (cache hit).
- `flush` 10 cycles after issuing DIV 50 / 5 → no response, `busy` high until `div_done`, `req_ready` high the cycle after. The next DIV 50 / 5 hits the cache and returns 10.
- `resp_ready` held low for 20 cycles → `resp_valid`, data and tag stable and `req_ready` low throughout. Then `rst` low for one cycle → all outputs at reset values.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension divide path: widths, divide/remainder
// op codes ({opcode[6:0], funct3}), the controller state enum and a small
// op-decoding helper. Used by the decoder, the divider and the controller.
package muldiv_pkg;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned TAG_W = 5;
    localparam int unsigned OP_W  = 10;

    localparam logic [6:0] OPC_OP   = 7'b0110011;
    localparam logic [6:0] OPC_OP32 = 7'b0111011;

    localparam logic [OP_W-1:0] OP_DIV   = {OPC_OP, 3'b100};
    localparam logic [OP_W-1:0] OP_DIVU  = {OPC_OP, 3'b101};
    localparam logic [OP_W-1:0] OP_REM   = {OPC_OP, 3'b110};
    localparam logic [OP_W-1:0] OP_REMU  = {OPC_OP, 3'b111};
    localparam logic [OP_W-1:0] OP_DIVW  = {OPC_OP32, 3'b100};
    localparam logic [OP_W-1:0] OP_DIVUW = {OPC_OP32, 3'b101};
    localparam logic [OP_W-1:0] OP_REMW  = {OPC_OP32, 3'b110};
    localparam logic [OP_W-1:0] OP_REMUW = {OPC_OP32, 3'b111};

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StDrain,
        StResp
    } div_state_e;

    // True for the 32-bit (W) forms.
    function automatic logic is_w_op(input logic [OP_W-1:0] op);
        return op[OP_W-1:3] == OPC_OP32;
    endfunction

endpackage

// File: rtl/div_special_case.sv
// Combinational classifier for divide/remainder requests that need no divider.
// Ports:
//   op, rs1, rs2 : request op code and operands
//   is_zero      : divisor is zero (low 32 bits for W forms)
//   is_ovf       : signed overflow (most-negative / -1)
//   is_bad_op    : op code is not one of the eight divide/remainder ops
//   result       : fast-path result, valid when any of the three flags is set
module div_special_case
    import muldiv_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            is_zero,
    output logic            is_ovf,
    output logic            is_bad_op,
    output logic [XLEN-1:0] result
);

    logic            is_w;
    logic            is_rem;
    logic            is_signed;
    logic            div0;
    logic            ovf;
    logic [XLEN-1:0] rs1_w;

    always_comb begin
        is_w      = is_w_op(op);
        is_bad_op = !(((op[OP_W-1:3] == OPC_OP) || is_w) && op[2]);
        is_rem    = op[1];
        is_signed = !op[0];
        rs1_w     = {{32{rs1[31]}}, rs1[31:0]};

        div0 = is_w ? (rs2[31:0] == 32'h0) : (rs2 == '0);
        ovf  = is_signed && (is_w ? ((rs1[31:0] == 32'h8000_0000) && (rs2[31:0] == '1))
                                  : ((rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1)));

        is_zero = !is_bad_op && div0;
        is_ovf  = !is_bad_op && ovf;

        // Unlisted op codes fall through to zero.
        result = '0;
        if (is_zero) begin
            result = is_rem ? (is_w ? rs1_w : rs1) : '1;
        end else if (is_ovf) begin
            // For W forms rs1[31:0] is 0x80000000 here, so rs1_w is the
            // sign-extended most-negative value.
            result = is_rem ? '0 : (is_w ? rs1_w : rs1);
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// Sequencer between execute and the iterative radix-2 divider. Resolves
// divide-by-zero, signed overflow, unlisted ops and single-entry cache hits
// in one cycle; launches the divider for everything else and returns results
// on a valid/ready port. Flush drops in-flight work (draining the divider).
// Ports:
//   clk, rst (sync, active low), flush
//   req_*  : request handshake, op code, operands, destination tag
//   resp_* : response handshake, result, tag
//   busy   : controller not idle
//   div_*  : divider launch pulse, held operands, busy/done/result from divider
module div_ctrl
    import muldiv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OP_W-1:0]  req_op,
    input  logic [XLEN-1:0]  req_rs1,
    input  logic [XLEN-1:0]  req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy,
    output logic             div_start,
    output logic [OP_W-1:0]  div_op,
    output logic [XLEN-1:0]  div_dividend,
    output logic [XLEN-1:0]  div_divisor,
    input  logic             div_busy,
    input  logic             div_done,
    input  logic [XLEN-1:0]  div_result
);

    div_state_e       state_q, state_d;
    logic [OP_W-1:0]  op_q;
    logic [XLEN-1:0]  rs1_q, rs2_q, result_q, result_d;
    logic [TAG_W-1:0] tag_q;
    logic             start_q, start_d;
    logic             cache_valid_q;
    logic [OP_W-1:0]  cache_op_q;
    logic [XLEN-1:0]  cache_rs1_q, cache_rs2_q, cache_result_q;

    logic            sc_zero, sc_ovf, sc_bad;
    logic [XLEN-1:0] sc_result;
    logic            cache_hit, accept, cache_we;

    div_special_case u_special (
        .op        (req_op),
        .rs1       (req_rs1),
        .rs2       (req_rs2),
        .is_zero   (sc_zero),
        .is_ovf    (sc_ovf),
        .is_bad_op (sc_bad),
        .result    (sc_result)
    );

    assign cache_hit = cache_valid_q && (req_op == cache_op_q) &&
                       (req_rs1 == cache_rs1_q) && (req_rs2 == cache_rs2_q);

    always_comb begin
        state_d    = state_q;
        start_d    = 1'b0;
        result_d   = result_q;
        accept     = 1'b0;
        cache_we   = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_ready = !flush && rst;
                if (req_valid && !flush) begin
                    accept = 1'b1;
                    if (sc_zero || sc_ovf || sc_bad) begin
                        result_d = sc_result;
                        state_d  = StResp;
                    end else if (cache_hit) begin
                        result_d = cache_result_q;
                        state_d  = StResp;
                    end else begin
                        start_d = !div_busy && !div_done;
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (start_q) begin
                    // Pulse is on the wire this cycle; the divider will finish.
                    state_d = flush ? StDrain : StWait;
                end else if (flush) begin
                    state_d = StIdle;
                end else begin
                    start_d = !div_busy && !div_done;
                end
            end
            StWait: begin
                if (div_done) begin
                    cache_we = 1'b1;
                    if (flush) begin
                        state_d = StIdle;
                    end else begin
                        result_d = div_result;
                        state_d  = StResp;
                    end
                end else if (flush) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (div_done) begin
                    cache_we = 1'b1;
                    state_d  = StIdle;
                end
            end
            StResp: begin
                resp_valid = !flush;
                if (flush || resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= StIdle;
            start_q        <= 1'b0;
            op_q           <= '0;
            rs1_q          <= '0;
            rs2_q          <= '0;
            tag_q          <= '0;
            result_q       <= '0;
            cache_valid_q  <= 1'b0;
            cache_op_q     <= '0;
            cache_rs1_q    <= '0;
            cache_rs2_q    <= '0;
            cache_result_q <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            result_q <= result_d;
            if (accept) begin
                op_q  <= req_op;
                rs1_q <= req_rs1;
                rs2_q <= req_rs2;
                tag_q <= req_tag;
            end
            if (cache_we) begin
                cache_valid_q  <= 1'b1;
                cache_op_q     <= op_q;
                cache_rs1_q    <= rs1_q;
                cache_rs2_q    <= rs2_q;
                cache_result_q <= div_result;
            end
        end
    end

    assign resp_data    = result_q;
    assign resp_tag     = tag_q;
    assign busy         = state_q != StIdle;
    assign div_start    = start_q;
    assign div_op       = op_q;
    assign div_dividend = rs1_q;
    assign div_divisor  = rs2_q;

endmodule
